// File: rtl/scatter_sequencer_pkg.sv
// Shared definitions for the scatter/solve loop: step select encoding,
// sequencer states and the pipeline depths the scatterer also depends on.
package scatter_sequencer_pkg;

    // Step select seen by the scatterer.
    typedef enum logic [1:0] {
        STEP_IDLE    = 2'd0,
        STEP_SCATTER = 2'd1,
        STEP_SOLVE   = 2'd2
    } step_t;

    // Sequencer phases.
    typedef enum logic [2:0] {
        S_IDLE,
        S_SCATTER,
        S_DRAIN,
        S_SOLVE,
        S_SOLVE_DRAIN,
        S_SWAP
    } seq_state_t;

    // Cycles from the last scatter strobe until its accumulator write is in BRAM.
    localparam int DRAIN_CYCLES_DEFAULT = 8;
    // Cycles from an accepted grid-read request to valid charge_out.
    localparam int SOLVE_LAT_DEFAULT    = 7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scatter_sequencer_valid_delay.sv
// Fixed-depth valid shift register: valid_o follows valid_i after DEPTH cycles.
module scatter_sequencer_valid_delay #(
    parameter int DEPTH = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    output logic valid_o
);

    logic [DEPTH-1:0] shreg_q;

    // Shift one stage per cycle; reset discards every in-flight valid.
    // NOTE: unlike a data RAM, this valid pipe must be reset, otherwise stale
    // bits would emerge as phantom responses after a mid-iteration reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q[0] <= valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                shreg_q[i] <= shreg_q[i-1];
            end
        end
    end

    assign valid_o = shreg_q[DEPTH-1];

endmodule

// File: rtl/scatter_sequencer.sv
// Phase controller for the scatter/solve loop: SCATTER -> DRAIN -> SOLVE ->
// SOLVE_DRAIN -> SWAP. Gates pusher particles and solver requests, delays
// solver response valids by the grid read latency, and counts iterations.
module scatter_sequencer
    import scatter_sequencer_pkg::*;
#(
    parameter int NUM_PARTICLES = 4096,
    parameter int PCNT_W        = 16,
    parameter int DRAIN_CYCLES  = DRAIN_CYCLES_DEFAULT,
    parameter int SOLVE_LAT     = SOLVE_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output step_t       step,
    input  logic        p_valid,
    input  logic        p_last,
    output logic        p_ready,
    output logic        valid_scatter,
    input  logic        s_req_valid,
    input  logic        s_req_last,
    output logic        s_req_ready,
    output logic        valid_req,
    output logic        s_resp_valid,
    output logic        swap_banks,
    output logic        iter_done,
    output logic [15:0] iter_count,
    output logic        count_err
);

    // One down-counter serves both drain phases, so size it for the longer one.
    localparam int DCNT_MAX = max_int(DRAIN_CYCLES, SOLVE_LAT);
    localparam int DCNT_W   = (DCNT_MAX > 1) ? $clog2(DCNT_MAX) : 1;

    seq_state_t        state_q;
    step_t             step_q;
    logic              busy_q;
    logic              p_ready_q;
    logic              s_req_ready_q;
    logic              swap_q;
    logic              done_q;
    logic [15:0]       iter_count_q;
    logic              count_err_q;
    logic [PCNT_W-1:0] pcnt_q;
    logic [DCNT_W-1:0] dcnt_q;

    logic p_accept;
    logic req_accept;
    logic pcnt_at_end;

    assign p_accept    = p_valid & p_ready_q;
    assign req_accept  = s_req_valid & s_req_ready_q;
    assign pcnt_at_end = (pcnt_q == PCNT_W'(NUM_PARTICLES - 1));

    // Phase FSM; every output it drives is registered alongside the state.
    // NOTE: non-blocking assignments throughout, so every branch reads the
    // pre-edge values of state and counters regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            step_q        <= STEP_IDLE;
            busy_q        <= 1'b0;
            p_ready_q     <= 1'b0;
            s_req_ready_q <= 1'b0;
            swap_q        <= 1'b0;
            done_q        <= 1'b0;
            iter_count_q  <= '0;
            count_err_q   <= 1'b0;
            pcnt_q        <= '0;
            dcnt_q        <= '0;
        end else begin
            swap_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_SCATTER;
                        step_q    <= STEP_SCATTER;
                        busy_q    <= 1'b1;
                        p_ready_q <= 1'b1;
                        pcnt_q    <= '0;
                    end
                end
                S_SCATTER: begin
                    if (p_accept) begin
                        pcnt_q <= pcnt_q + PCNT_W'(1);
                        // Either end marker closes the phase; disagreement is flagged.
                        if (p_last || pcnt_at_end) begin
                            state_q   <= S_DRAIN;
                            p_ready_q <= 1'b0;
                            dcnt_q    <= DCNT_W'(DRAIN_CYCLES - 1);
                            if (p_last != pcnt_at_end) begin
                                count_err_q <= 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (dcnt_q == '0) begin
                        state_q       <= S_SOLVE;
                        step_q        <= STEP_SOLVE;
                        s_req_ready_q <= 1'b1;
                    end else begin
                        dcnt_q <= dcnt_q - DCNT_W'(1);
                    end
                end
                S_SOLVE: begin
                    if (req_accept && s_req_last) begin
                        state_q       <= S_SOLVE_DRAIN;
                        s_req_ready_q <= 1'b0;
                        dcnt_q        <= DCNT_W'(SOLVE_LAT - 1);
                    end
                end
                S_SOLVE_DRAIN: begin
                    if (dcnt_q == '0) begin
                        state_q      <= S_SWAP;
                        swap_q       <= 1'b1;
                        done_q       <= 1'b1;
                        iter_count_q <= iter_count_q + 16'd1;
                    end else begin
                        dcnt_q <= dcnt_q - DCNT_W'(1);
                    end
                end
                S_SWAP: begin
                    state_q <= S_IDLE;
                    step_q  <= STEP_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q       <= S_IDLE;
                    step_q        <= STEP_IDLE;
                    busy_q        <= 1'b0;
                    p_ready_q     <= 1'b0;
                    s_req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Response valids trail accepted requests by the grid read latency.
    scatter_sequencer_valid_delay #(
        .DEPTH (SOLVE_LAT)
    ) u_resp_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (req_accept),
        .valid_o (s_resp_valid)
    );

    assign busy          = busy_q;
    assign step          = step_q;
    assign p_ready       = p_ready_q;
    assign valid_scatter = p_accept;
    assign s_req_ready   = s_req_ready_q;
    assign valid_req     = req_accept;
    assign swap_banks    = swap_q;
    assign iter_done     = done_q;
    assign iter_count    = iter_count_q;
    assign count_err     = count_err_q;

endmodule

// File: tb/tb_scatter_sequencer.sv
// Directed bench for scatter_sequencer with NUM_PARTICLES=4, DRAIN=8, SOLVE_LAT=7.
module tb_scatter_sequencer;
    import scatter_sequencer_pkg::*;

    localparam logic [1:0] ST_I = 2'(STEP_IDLE);
    localparam logic [1:0] ST_C = 2'(STEP_SCATTER);
    localparam logic [1:0] ST_S = 2'(STEP_SOLVE);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, p_valid, p_last, s_req_valid, s_req_last;
    logic        busy, p_ready, valid_scatter, s_req_ready, valid_req;
    logic        s_resp_valid, swap_banks, iter_done, count_err;
    logic [15:0] iter_count;
    step_t       step;

    int n_checks = 0;
    int n_pass   = 0;

    // {iter_count, busy, step, p_ready, valid_scatter, s_req_ready, valid_req,
    //  s_resp_valid, swap_banks, iter_done, count_err}
    logic [26:0] obs;
    assign obs = {iter_count, busy, step, p_ready, valid_scatter, s_req_ready,
                  valid_req, s_resp_valid, swap_banks, iter_done, count_err};

    always #5 clk = ~clk;

    scatter_sequencer #(
        .NUM_PARTICLES (4),
        .PCNT_W        (16),
        .DRAIN_CYCLES  (8),
        .SOLVE_LAT     (7)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .step          (step),
        .p_valid       (p_valid),
        .p_last        (p_last),
        .p_ready       (p_ready),
        .valid_scatter (valid_scatter),
        .s_req_valid   (s_req_valid),
        .s_req_last    (s_req_last),
        .s_req_ready   (s_req_ready),
        .valid_req     (valid_req),
        .s_resp_valid  (s_resp_valid),
        .swap_banks    (swap_banks),
        .iter_done     (iter_done),
        .iter_count    (iter_count),
        .count_err     (count_err)
    );

    // in = {start, p_valid, p_last, s_req_valid, s_req_last}
    // fl = {busy, p_ready, valid_scatter, s_req_ready, valid_req, s_resp_valid, swap_banks, iter_done}
    typedef struct {
        int          reps;
        logic [4:0]  in;
        logic [1:0]  st;
        logic [7:0]  fl;
        logic [15:0] ic;
    } vec_t;

    vec_t tbl[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One clock cycle: apply inputs just after the edge, return at the falling edge.
    task automatic drive(input logic [4:0] in);
        @(posedge clk);
        #1;
        {start, p_valid, p_last, s_req_valid, s_req_last} = in;
        @(negedge clk);
    endtask

    // Issue one last-request once SOLVE opens and run until iter_done (bounded).
    task automatic finish_iter(output bit seen);
        bit sent;
        seen = 1'b0;
        sent = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (!sent && s_req_ready) begin
                drive(5'b00011);
                sent = 1'b1;
            end else begin
                drive(5'b00000);
            end
            if (iter_done) seen = 1'b1;
        end
    endtask

    initial begin
        bit seen;
        bit resp_seen;
        bit found;

        rst_n = 1'b0;
        {start, p_valid, p_last, s_req_valid, s_req_last} = 5'b0;
        #3;
        check("reset_state", 32'(obs), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Iteration 1 nominal; iteration 2 holds p_valid through every later
        // phase and pulses start during SOLVE.
        tbl[0]  = '{1, 5'b10000, ST_I, 8'b00000000, 16'd0};
        tbl[1]  = '{3, 5'b01000, ST_C, 8'b11100000, 16'd0};
        tbl[2]  = '{1, 5'b01100, ST_C, 8'b11100000, 16'd0};
        tbl[3]  = '{8, 5'b00000, ST_C, 8'b10000000, 16'd0};
        tbl[4]  = '{2, 5'b00010, ST_S, 8'b10011000, 16'd0};
        tbl[5]  = '{1, 5'b00011, ST_S, 8'b10011000, 16'd0};
        tbl[6]  = '{4, 5'b00000, ST_S, 8'b10000000, 16'd0};
        tbl[7]  = '{3, 5'b00000, ST_S, 8'b10000100, 16'd0};
        tbl[8]  = '{1, 5'b00000, ST_S, 8'b10000011, 16'd1};
        tbl[9]  = '{1, 5'b00000, ST_I, 8'b00000000, 16'd1};
        tbl[10] = '{1, 5'b10000, ST_I, 8'b00000000, 16'd1};
        tbl[11] = '{3, 5'b01000, ST_C, 8'b11100000, 16'd1};
        tbl[12] = '{1, 5'b01100, ST_C, 8'b11100000, 16'd1};
        tbl[13] = '{8, 5'b01000, ST_C, 8'b10000000, 16'd1};
        tbl[14] = '{1, 5'b11010, ST_S, 8'b10011000, 16'd1};
        tbl[15] = '{1, 5'b01010, ST_S, 8'b10011000, 16'd1};
        tbl[16] = '{1, 5'b01011, ST_S, 8'b10011000, 16'd1};
        tbl[17] = '{4, 5'b01000, ST_S, 8'b10000000, 16'd1};
        tbl[18] = '{3, 5'b01000, ST_S, 8'b10000100, 16'd1};
        tbl[19] = '{1, 5'b01000, ST_S, 8'b10000011, 16'd2};
        tbl[20] = '{1, 5'b01000, ST_I, 8'b00000000, 16'd2};
        tbl[21] = '{3, 5'b00000, ST_I, 8'b00000000, 16'd2};

        for (int r = 0; r < 22; r++) begin
            for (int k = 0; k < tbl[r].reps; k++) begin
                drive(tbl[r].in);
                check($sformatf("vec%0d_%0d", r, k), 32'(obs),
                      32'({tbl[r].ic, tbl[r].fl[7], tbl[r].st, tbl[r].fl[6:0], 1'b0}));
            end
        end

        // Async reset mid-SOLVE with three responses in flight.
        drive(5'b10000);
        repeat (3) drive(5'b01000);
        drive(5'b01100);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive(5'b00000);
            if (s_req_ready) found = 1'b1;
        end
        check("rst_reach_solve", 32'(found), 32'd1);
        repeat (3) drive(5'b00010);
        repeat (2) drive(5'b00000);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", 32'(obs), 32'd0);
        resp_seen = 1'b0;
        repeat (2) begin
            drive(5'b00000);
            if (s_resp_valid) resp_seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (12) begin
            drive(5'b00000);
            if (s_resp_valid) resp_seen = 1'b1;
        end
        check("rst_no_stale_resp", 32'(resp_seen), 32'd0);
        check("rst_idle", 32'(busy), 32'd0);
        drive(5'b10000);
        repeat (3) drive(5'b01000);
        drive(5'b01100);
        finish_iter(seen);
        check("rst_clean_done", 32'(seen), 32'd1);
        check("rst_clean_count", 32'(iter_count), 32'd1);
        check("rst_clean_err", 32'(count_err), 32'd0);
        drive(5'b00000);

        // Early p_last on particle 2 of 4.
        drive(5'b10000);
        drive(5'b01000);
        drive(5'b01100);
        drive(5'b00000);
        check("early_err", 32'(count_err), 32'd1);
        check("early_drain_ready", 32'(p_ready), 32'd0);
        check("early_drain_step", 32'(step), 32'(ST_C));
        finish_iter(seen);
        check("early_done", 32'(seen), 32'd1);
        check("early_count", 32'(iter_count), 32'd2);
        drive(5'b00000);

        // Sticky error survives until reset.
        check("err_sticky", 32'(count_err), 32'd1);
        rst_n = 1'b0;
        #1;
        check("err_cleared", 32'(count_err), 32'd0);
        drive(5'b00000);
        rst_n = 1'b1;

        // Missing p_last: 4th accept closes SCATTER with an error.
        drive(5'b10000);
        repeat (3) drive(5'b01000);
        drive(5'b01000);
        check("miss_4th_ready", 32'(p_ready), 32'd1);
        check("miss_no_early_err", 32'(count_err), 32'd0);
        drive(5'b00000);
        check("miss_err", 32'(count_err), 32'd1);
        check("miss_drain_ready", 32'(p_ready), 32'd0);
        repeat (7) drive(5'b00000);
        check("miss_drain_len", 32'(step), 32'(ST_C));
        drive(5'b00000);
        check("miss_solve_at_9", 32'(step), 32'(ST_S));
        finish_iter(seen);
        check("miss_done", 32'(seen), 32'd1);
        check("miss_count", 32'(iter_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
